mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-wide data memory.
//  - Handles byte, halfword and word loads, with sign or zero extension.
//  - Handles byte and halfword stores by a two-cycle read-modify-write on the word memory.
//  - Stalls the pipeline during a RMW and flags misaligned accesses.
// PARAMETERS
//  ADDR_W      6   word-address width driven to data memory (64 words)
//  BIG_ENDIAN  0   0: byte 0 = bits [7:0]; 1: byte 0 = bits [31:24]
// PORTS
//  clk          in   1       single clock; all state updates on posedge
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       memory op present in MEM stage
//  req_we       in   1       1 = store, 0 = load
//  req_size     in   2       00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
//  req_unsigned in   1       load zero-extends when 1 (lbu/lhu)
//  req_addr     in   32      byte address
//  req_wdata    in   32      store data, right-justified
//  rdata        out  32      aligned, extended load data (combinational)
//  stall        out  1       hold EX/MEM and earlier stages this cycle
//  misalign     out  1       access rejected: no memory write
//  dm_we        out  1       data memory write enable
//  dm_a         out  ADDR_W  word address = req_addr[ADDR_W+1:2]; req_addr upper bits ignored
//  dm_d         out  32      data memory write data
//  dm_q         in   32      data memory read data (combinational from dm_a)
// BEHAVIOUR
//  - FSM states IDLE and RMW_WR. Reset sets state=IDLE and merge_q=0.
//    stall, dm_we and misalign are 0 while rst=1.
//  - misalign = req_valid & (size==11 | (half & a[0]) | (word & a[1:0]!=0)).
//    It is combinational, never stalls, and forces dm_we=0.
//  - IDLE, load: dm_we=0, stall=0.
//    rdata = dm_q lane selected by a[1:0] (byte) or a[1] (half), sign- or zero-extended. Zero latency.
//  - IDLE, word store: dm_we=1, dm_d=req_wdata, stall=0. Memory written at this posedge.
//  - IDLE, byte/half store: stall=1, dm_we=0.
//    merge_q <= dm_q with the addressed lane(s) replaced by req_wdata[7:0]/[15:0]; next state RMW_WR.
//  - RMW_WR: dm_we=1, dm_d=merge_q, stall=0. Next state IDLE.
//    Upstream must hold req_* stable across the stall cycle.
//  - No back-to-back hazard: a request is accepted the cycle after RMW_WR only because stall has dropped.
//  - rdata is don't-care for stores. For misaligned loads rdata is still the lane-selected value.
//    Upstream handles the exception.
//  - req_valid=0: dm_we=0, stall=0, misalign=0; state stays IDLE.
//  - Reset asserted in RMW_WR: write suppressed (dm_we=0), state -> IDLE, merge_q cleared.
//  - BIG_ENDIAN mirrors lane selection: byte lane = 3-a[1:0], half lane = 1-a[1].
// STRUCTURE
//  - Package mem_pkg:
//    - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
//    - state enum {ST_IDLE, ST_RMW_WR}
//    - function lane_shift(size, a[1:0], big_endian)
//  - Sub-module store_merge (combinational): (old word, new data, size, a[1:0]) -> merged word.
//    The same lane logic is mirrored for load extraction in the top level.
// TESTING
//  1. mem[3]=0x11223344 and rst released. lb at 0x0C -> 0x00000044. lb at 0x0F -> 0x00000011. All zero-latency.
//  2. mem[3]=0x80FF7F01. lh at 0x0E -> 0xFFFF80FF. lhu at 0x0E -> 0x000080FF. lb at 0x0D -> 0x0000007F.
//  3. sw 0xDEADBEEF at 0x10: dm_we=1 in the same cycle, stall=0. Then lw 0x10 -> 0xDEADBEEF.
//  4. mem[4]=0xDEADBEEF. sb 0xAA at 0x11: stall=1 for 1 cycle, then dm_we=1 with dm_d=0xDEADAAEF.
//     Then sh 0x1234 at 0x12: final word 0x1234AAEF.
//  5. sh at 0x13 -> misalign=1, dm_we=0, stall=0. lw at 0x12 -> misalign=1. Memory unchanged.
//  6. Start sb at 0x20, assert rst in RMW_WR: no write, state IDLE next cycle, stall=0.
//     Word at 0x20 keeps its old value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and lane arithmetic for the MEM-stage load/store unit.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {ST_IDLE, ST_RMW_WR} state_e;

   // Bit offset of the addressed byte/half lane inside the 32-bit word; 0 for word/reserved.
   function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                             input logic [1:0] a,
                                             input logic       big_endian);
      logic [4:0] sh;
      sh = '0;
      case (size)
         SZ_BYTE: sh = big_endian ? {~a, 3'b000} : {a, 3'b000};
         SZ_HALF: sh = {(big_endian ? ~a[1] : a[1]), 4'b0000};
         default: sh = '0;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane insert: replaces the addressed byte/half of a word with new store data.
module store_merge
   import mem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [31:0] old_word_i,
   input  logic [31:0] new_data_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  a_i,
   output logic [31:0] merged_o
);

   logic [4:0]  shift;
   logic [31:0] lane_mask;
   logic [31:0] new_lane;

   always_comb begin
      shift = lane_shift(size_i, a_i, BIG_ENDIAN);
      case (size_i)
         SZ_BYTE: begin
            lane_mask = 32'h0000_00FF;
            new_lane  = {24'b0, new_data_i[7:0]};
         end
         SZ_HALF: begin
            lane_mask = 32'h0000_FFFF;
            new_lane  = {16'b0, new_data_i[15:0]};
         end
         default: begin
            lane_mask = 32'hFFFF_FFFF;
            new_lane  = new_data_i;
         end
      endcase
      merged_o = (old_word_i & ~(lane_mask << shift)) | (new_lane << shift);
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: extended sub-word loads, word stores, and two-cycle RMW for
// byte/half stores against a word-wide data memory.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 6,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              misalign,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_a,
   output logic [31:0]       dm_d,
   input  logic [31:0]       dm_q
);

   state_e      state_q, state_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] merged;
   logic [31:0] lane;
   logic        mis_raw;
   logic        unused_addr;

   assign dm_a        = req_addr[ADDR_W+1:2];
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   store_merge #(
      .BIG_ENDIAN(BIG_ENDIAN)
   ) u_store_merge (
      .old_word_i(dm_q),
      .new_data_i(req_wdata),
      .size_i    (req_size),
      .a_i       (req_addr[1:0]),
      .merged_o  (merged)
   );

   always_comb begin
      mis_raw = (req_size == SZ_RSVD)
              | ((req_size == SZ_HALF) & req_addr[0])
              | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
      misalign = ~rst & req_valid & mis_raw;
   end

   // Load extraction mirrors the store_merge lane selection.
   always_comb begin
      lane = dm_q >> lane_shift(req_size, req_addr[1:0], BIG_ENDIAN);
      case (req_size)
         SZ_BYTE: rdata = {{24{~req_unsigned & lane[7]}}, lane[7:0]};
         SZ_HALF: rdata = {{16{~req_unsigned & lane[15]}}, lane[15:0]};
         default: rdata = dm_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      merge_d = merge_q;
      stall   = 1'b0;
      dm_we   = 1'b0;
      dm_d    = req_wdata;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_we && !mis_raw) begin
               if (req_size == SZ_WORD) begin
                  dm_we = 1'b1;
               end else begin
                  stall   = 1'b1;
                  merge_d = merged;
                  state_d = ST_RMW_WR;
               end
            end
         end
         ST_RMW_WR: begin
            dm_we   = 1'b1;
            dm_d    = merge_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Reset wins over any pending RMW write-back.
      if (rst) begin
         stall   = 1'b0;
         dm_we   = 1'b0;
         state_d = ST_IDLE;
         merge_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         merge_q <= '0;
      end else begin
         state_q <= state_d;
         merge_q <= merge_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random ops against a
// byte-level reference model of the data memory.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        misalign;
   logic        dm_we;
   logic [5:0]  dm_a;
   logic [31:0] dm_d;
   logic [31:0] dm_q;

   logic [31:0] mem [64];
   logic        pl_en;
   logic [5:0]  pl_addr;
   logic [31:0] pl_data;

   bit   [31:0] exp_mem [64];
   int          n_vec;
   int          n_fail;

   mem_access_unit #(
      .ADDR_W    (6),
      .BIG_ENDIAN(1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_unsigned(req_unsigned),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rdata       (rdata),
      .stall       (stall),
      .misalign    (misalign),
      .dm_we       (dm_we),
      .dm_a        (dm_a),
      .dm_d        (dm_d),
      .dm_q        (dm_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_q = mem[dm_a];

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (dm_we) mem[dm_a] <= dm_d;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic bit [31:0] ref_load(bit [31:0] w, bit [1:0] off, bit [1:0] sz, bit uns);
      bit [31:0] v;
      if (sz == 2'd0) begin
         v = (w / (32'd1 << (8 * off))) % 32'd256;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w / (32'd1 << (16 * (off / 2)))) % 32'd65536;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic bit [31:0] ref_merge(bit [31:0] w, bit [31:0] wd, bit [1:0] off, bit [1:0] sz);
      bit [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = 8'(w >> (8 * i));
      if (sz == 2'd0) begin
         b[off] = wd[7:0];
      end else begin
         b[{off[1], 1'b0}] = wd[7:0];
         b[{off[1], 1'b1}] = wd[15:8];
      end
      return {b[3], b[2], b[1], b[0]};
   endfunction

   function automatic bit ref_mis(bit [1:0] sz, bit [31:0] addr);
      return (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
   endfunction

   task automatic set_word(input int idx, input bit [31:0] val);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 6'(idx);
      pl_data = val;
      exp_mem[idx] = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // One request, including the stall cycle of a sub-word store; returns rdata or written word.
   task automatic do_op(input string tag, input bit we, input bit [1:0] sz, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wd, output bit [31:0] got);
      int        idx;
      bit        mis;
      bit [31:0] old;
      idx = int'(addr[7:2]);
      mis = ref_mis(sz, addr);
      old = exp_mem[idx];
      got = '0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      #1;
      check({tag, " misalign"}, 32'(misalign), 32'(mis));
      check({tag, " dm_a"}, 32'(dm_a), 32'(idx));
      if (!we) begin
         if (sz != 2'd3) check({tag, " rdata"}, rdata, ref_load(old, addr[1:0], sz, uns));
         check({tag, " stall"}, 32'(stall), 32'd0);
         check({tag, " dm_we"}, 32'(dm_we), 32'd0);
         got = rdata;
      end else if (mis) begin
         check({tag, " dm_we"}, 32'(dm_we), 32'd0);
         check({tag, " stall"}, 32'(stall), 32'd0);
      end else if (sz == 2'd2) begin
         check({tag, " dm_we"}, 32'(dm_we), 32'd1);
         check({tag, " stall"}, 32'(stall), 32'd0);
         check({tag, " dm_d"}, dm_d, wd);
         exp_mem[idx] = wd;
         got = dm_d;
      end else begin
         check({tag, " stall"}, 32'(stall), 32'd1);
         check({tag, " dm_we"}, 32'(dm_we), 32'd0);
         @(negedge clk);
         #1;
         check({tag, " wb stall"}, 32'(stall), 32'd0);
         check({tag, " wb dm_we"}, 32'(dm_we), 32'd1);
         check({tag, " wb dm_d"}, dm_d, ref_merge(old, wd, addr[1:0], sz));
         exp_mem[idx] = ref_merge(old, wd, addr[1:0], sz);
         got = dm_d;
      end
   endtask

   initial begin
      bit [31:0] got;
      bit [31:0] old8;
      n_vec        = 0;
      n_fail       = 0;
      rst          = 1'b1;
      pl_en        = 1'b0;
      pl_addr      = '0;
      pl_data      = '0;
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_addr     = 32'h0000_0004;
      req_wdata    = 32'hCAFE_F00D;

      // Outputs held quiet during reset even with a live request.
      @(negedge clk);
      #1;
      check("rst dm_we", 32'(dm_we), 32'd0);
      check("rst stall", 32'(stall), 32'd0);
      req_size = 2'd3;
      #1;
      check("rst misalign", 32'(misalign), 32'd0);
      req_size = 2'd0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst sb stall", 32'(stall), 32'd0);
      req_valid = 1'b0;

      for (int i = 0; i < 64; i++) set_word(i, $urandom);
      set_word(3, 32'h1122_3344);
      @(negedge clk);
      rst = 1'b0;

      do_op("t1 lb 0C", 1'b0, 2'd0, 1'b0, 32'h0000_000C, 32'h0, got);
      check("t1 lb 0C lit", got, 32'h0000_0044);
      do_op("t1 lb 0F", 1'b0, 2'd0, 1'b0, 32'h0000_000F, 32'h0, got);
      check("t1 lb 0F lit", got, 32'h0000_0011);

      set_word(3, 32'h80FF_7F01);
      do_op("t2 lh 0E", 1'b0, 2'd1, 1'b0, 32'h0000_000E, 32'h0, got);
      check("t2 lh 0E lit", got, 32'hFFFF_80FF);
      do_op("t2 lhu 0E", 1'b0, 2'd1, 1'b1, 32'h0000_000E, 32'h0, got);
      check("t2 lhu 0E lit", got, 32'h0000_80FF);
      do_op("t2 lb 0D", 1'b0, 2'd0, 1'b0, 32'h0000_000D, 32'h0, got);
      check("t2 lb 0D lit", got, 32'h0000_007F);

      do_op("t3 sw 10", 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, got);
      do_op("t3 lw 10", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, got);
      check("t3 lw 10 lit", got, 32'hDEAD_BEEF);

      set_word(4, 32'hDEAD_BEEF);
      do_op("t4 sb 11", 1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_00AA, got);
      check("t4 sb 11 lit", got, 32'hDEAD_AAEF);
      do_op("t4 sh 12", 1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000_1234, got);
      check("t4 sh 12 lit", got, 32'h1234_AAEF);

      do_op("t5 sh 13", 1'b1, 2'd1, 1'b0, 32'h0000_0013, 32'h0000_5678, got);
      do_op("t5 lw 12", 1'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h0, got);
      check("t5 mem4", mem[4], 32'h1234_AAEF);

      // Reset during the write-back cycle must drop the write.
      old8 = exp_mem[8];
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd0;
      req_addr  = 32'h0000_0020;
      req_wdata = 32'h0000_0055;
      #1;
      check("t6 stall", 32'(stall), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6 rst dm_we", 32'(dm_we), 32'd0);
      check("t6 rst stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      #1;
      check("t6 idle stall", 32'(stall), 32'd0);
      check("t6 idle dm_we", 32'(dm_we), 32'd0);
      check("t6 mem8", mem[8], old8);
      do_op("t6 lw 20", 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, got);

      for (int n = 0; n < 150; n++) begin
         bit [31:0] ra;
         ra = $urandom;
         do_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ra, $urandom, got);
      end

      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 64; i++) check("final mem", mem[i], exp_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
